// File: rtl/bios_cmd_if.sv
// Command port and byte-stream bundle between a boot sequencer and the
// BIOS command encoder.
interface bios_cmd_if;
    logic        i_cmd_valid;
    logic        o_cmd_ready;
    logic        i_cmd_kind;
    logic [7:0]  i_opcode;
    logic [7:0]  i_arg_a;
    logic [7:0]  i_arg_b;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        i_out_ready;
    logic        o_busy;

    modport master (
        output i_cmd_valid, i_cmd_kind, i_opcode, i_arg_a, i_arg_b,
        output i_addr, i_wdata, i_out_ready,
        input  o_cmd_ready, o_data, o_valid, o_busy
    );

    modport slave (
        input  i_cmd_valid, i_cmd_kind, i_opcode, i_arg_a, i_arg_b,
        input  i_addr, i_wdata, i_out_ready,
        output o_cmd_ready, o_data, o_valid, o_busy
    );
endinterface

// File: rtl/bios_cmd_encoder.sv
// Serialises raw BIOS commands and word-write macros into the byte
// stream consumed by the BIOS dispatcher.
module bios_cmd_encoder #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter bit         SEND_SYNC = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      clk_en,
    bios_cmd_if.slave bus
);
    typedef enum logic [2:0] {
        S_SYNC, S_IDLE, S_OPC, S_ARG_A, S_ARG_B
    } state_t;

    state_t      r_state;
    logic        r_kind;
    logic [7:0]  r_opc;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_idx;
    logic [1:0]  r_phase;

    logic [31:0] w_addr_i;
    logic [7:0]  w_wbyte;
    logic [7:0]  w_cur_opc;
    logic [7:0]  w_cur_a;
    logic [7:0]  w_cur_b;
    logic [7:0]  w_next_opc;
    logic        w_xfer;
    logic        w_last_sub;
    logic        w_fin;

    assign w_addr_i   = r_addr + {30'd0, r_idx};
    assign w_wbyte    = r_wdata[{r_idx, 3'b000} +: 8];
    assign w_xfer     = bus.o_valid & bus.i_out_ready;
    assign w_last_sub = (r_idx == 2'd3) && (r_phase == 2'd2);

    // Macro phases map onto ADR_LOWER, ADR_UPPER, WRITE sub-commands
    always_comb begin
        w_cur_opc  = r_opc;
        w_cur_a    = r_a;
        w_cur_b    = r_b;
        w_next_opc = 8'h05;
        if (r_kind) begin
            unique case (r_phase)
                2'd0: begin
                    w_cur_opc  = 8'h05;
                    w_cur_a    = w_addr_i[7:0];
                    w_cur_b    = w_addr_i[15:8];
                    w_next_opc = 8'h06;
                end
                2'd1: begin
                    w_cur_opc  = 8'h06;
                    w_cur_a    = w_addr_i[23:16];
                    w_cur_b    = w_addr_i[31:24];
                    w_next_opc = 8'h04;
                end
                default: begin
                    w_cur_opc  = 8'h04;
                    w_cur_a    = w_wbyte;
                    w_cur_b    = 8'h00;
                    w_next_opc = 8'h05;
                end
            endcase
        end
    end

    always_comb begin
        w_fin = 1'b0;
        if (w_xfer) begin
            unique case (r_state)
                S_OPC:   w_fin = (w_cur_opc < 8'd4);
                S_ARG_A: w_fin = (w_cur_opc == 8'd4);
                S_ARG_B: w_fin = 1'b1;
                default: w_fin = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= SEND_SYNC ? S_SYNC : S_IDLE;
            bus.o_valid     <= 1'b0;
            bus.o_data      <= 8'h00;
            bus.o_cmd_ready <= SEND_SYNC ? 1'b0 : 1'b1;
            bus.o_busy      <= SEND_SYNC ? 1'b1 : 1'b0;
            r_kind          <= 1'b0;
            r_opc           <= 8'h00;
            r_a             <= 8'h00;
            r_b             <= 8'h00;
            r_addr          <= 32'd0;
            r_wdata         <= 32'd0;
            r_idx           <= 2'd0;
            r_phase         <= 2'd0;
        end else if (clk_en) begin
            unique case (r_state)
                S_SYNC: begin
                    if (!bus.o_valid) begin
                        bus.o_valid <= 1'b1;
                        bus.o_data  <= SYNC_BYTE;
                    end else if (bus.i_out_ready) begin
                        bus.o_valid     <= 1'b0;
                        bus.o_cmd_ready <= 1'b1;
                        bus.o_busy      <= 1'b0;
                        r_state         <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (bus.i_cmd_valid) begin
                        r_kind          <= bus.i_cmd_kind;
                        r_opc           <= bus.i_opcode;
                        r_a             <= bus.i_arg_a;
                        r_b             <= bus.i_arg_b;
                        r_addr          <= bus.i_addr;
                        r_wdata         <= bus.i_wdata;
                        r_idx           <= 2'd0;
                        r_phase         <= 2'd0;
                        bus.o_cmd_ready <= 1'b0;
                        bus.o_busy      <= 1'b1;
                        bus.o_valid     <= 1'b1;
                        bus.o_data      <= bus.i_cmd_kind ? 8'h05
                                                          : bus.i_opcode;
                        r_state         <= S_OPC;
                    end
                end
                S_OPC: begin
                    if (w_xfer) begin
                        bus.o_data <= w_cur_a;
                        r_state    <= S_ARG_A;
                    end
                end
                S_ARG_A: begin
                    if (w_xfer) begin
                        bus.o_data <= w_cur_b;
                        r_state    <= S_ARG_B;
                    end
                end
                default: ;
            endcase
            // Last byte of a sub-command: chain the next one or go idle
            if (w_fin) begin
                if (r_kind && !w_last_sub) begin
                    bus.o_data <= w_next_opc;
                    r_state    <= S_OPC;
                    if (r_phase == 2'd2) begin
                        r_phase <= 2'd0;
                        r_idx   <= r_idx + 2'd1;
                    end else begin
                        r_phase <= r_phase + 2'd1;
                    end
                end else begin
                    bus.o_valid     <= 1'b0;
                    bus.o_cmd_ready <= 1'b1;
                    bus.o_busy      <= 1'b0;
                    r_state         <= S_IDLE;
                end
            end
        end
    end
endmodule

// File: tb/tb_bios_cmd_encoder.sv
// Bench for bios_cmd_encoder: table vectors, hand sequences and a
// randomized run against a byte-list reference model.
module tb_bios_cmd_encoder;
    logic clk;
    logic rst;
    logic clk_en;

    bios_cmd_if b1();
    bios_cmd_if b0();

    bios_cmd_encoder #(.SYNC_BYTE(8'hA5), .SEND_SYNC(1'b1)) u_dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(b1)
    );

    bios_cmd_encoder #(.SYNC_BYTE(8'hA5), .SEND_SYNC(1'b0)) u_nosync (
        .clk(clk), .rst(rst), .clk_en(clk_en), .bus(b0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] opc;
        logic [7:0] a;
        logic [7:0] b;
        int         n;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
    } vec_t;

    vec_t       tbl [9];
    logic [7:0] m4 [32];
    logic [7:0] rx [$];
    logic [7:0] exq [$];
    int         total = 0;
    int         bad = 0;
    int         b0_bytes = 0;
    bit         rnd = 0;
    bit         garbage = 0;
    bit         hold_v = 0;
    logic [7:0] hold_d = 8'h00;

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // One clock: observe at negedge, then drive just after posedge
    task automatic tick();
        @(negedge clk);
        if (hold_v)
            chk("hold", {b1.o_valid, b1.o_data}, {1'b1, hold_d});
        if (!rst && clk_en && b1.o_valid && b1.i_out_ready)
            rx.push_back(b1.o_data);
        if (b0.o_valid) b0_bytes++;
        hold_v = !rst && b1.o_valid && !(clk_en && b1.i_out_ready);
        hold_d = b1.o_data;
        @(posedge clk);
        #1;
        if (rnd) begin
            b1.i_out_ready = ($urandom_range(0, 9) < 7);
            clk_en = ($urandom_range(0, 19) < 17);
        end
        #1;
    endtask

    task automatic compare_q(input string name);
        chk({name, "_len"}, rx.size(), exq.size());
        for (int i = 0; i < rx.size() && i < exq.size(); i++)
            chk(name, rx[i], exq[i]);
        rx.delete();
        exq.delete();
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (cyc < 600) begin
            tick();
            cyc++;
            b1.i_cmd_valid = 1'b0;
            if (b1.o_cmd_ready && !b1.o_valid) break;
            if (garbage && !b1.o_cmd_ready) begin
                b1.i_cmd_valid = 1'($urandom_range(0, 1));
                b1.i_cmd_kind  = 1'($urandom_range(0, 1));
                b1.i_opcode    = 8'($urandom);
                b1.i_addr      = $urandom;
            end
        end
        chk("idle_wait", {b1.o_cmd_ready, b1.o_valid}, 2'b10);
    endtask

    task automatic send(input logic k, input logic [7:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [31:0] ad, input logic [31:0] wd,
                        input bit lat, input logic [7:0] first);
        int n;
        b1.i_cmd_kind = k;
        b1.i_opcode   = op;
        b1.i_arg_a    = a;
        b1.i_arg_b    = b;
        b1.i_addr     = ad;
        b1.i_wdata    = wd;
        b1.i_cmd_valid = 1'b1;
        n = 0;
        while (!(b1.o_cmd_ready && clk_en) && n < 600) begin
            tick();
            n++;
        end
        if (n >= 600) chk("accept_wait", b1.o_cmd_ready, 1'b1);
        tick();
        b1.i_cmd_valid = 1'b0;
        if (lat) chk("first_byte", {b1.o_valid, b1.o_data}, {1'b1, first});
    endtask

    // Reference: byte list derived directly from the protocol rules
    task automatic push_model(input logic k, input logic [7:0] op,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [31:0] ad, input logic [31:0] wd);
        logic [31:0] ai;
        logic [31:0] sh;
        logic [7:0]  raw [3];
        int          n;
        if (k) begin
            for (int i = 0; i < 4; i++) begin
                ai = ad + 32'(i);
                sh = wd >> (8 * i);
                exq.push_back(8'h05);
                exq.push_back(ai[7:0]);
                exq.push_back(ai[15:8]);
                exq.push_back(8'h06);
                exq.push_back(ai[23:16]);
                exq.push_back(ai[31:24]);
                exq.push_back(8'h04);
                exq.push_back(sh[7:0]);
            end
        end else begin
            raw = '{op, a, b};
            n = (op < 8'd4) ? 1 : (op == 8'd4) ? 2 : 3;
            for (int i = 0; i < n; i++) exq.push_back(raw[i]);
        end
    endtask

    initial begin
        int cyc;
        int n;
        logic       k;
        logic [7:0] op;
        logic [31:0] ad;
        logic [31:0] wd;

        tbl[0] = '{8'h04, 8'h5A, 8'h00, 2, 8'h04, 8'h5A, 8'h00};
        tbl[1] = '{8'h05, 8'h34, 8'h12, 3, 8'h05, 8'h34, 8'h12};
        tbl[2] = '{8'h09, 8'h11, 8'h22, 3, 8'h09, 8'h11, 8'h22};
        tbl[3] = '{8'h03, 8'h77, 8'h66, 1, 8'h03, 8'h00, 8'h00};
        tbl[4] = '{8'h00, 8'hFF, 8'hFF, 1, 8'h00, 8'h00, 8'h00};
        tbl[5] = '{8'h07, 8'h01, 8'h02, 3, 8'h07, 8'h01, 8'h02};
        tbl[6] = '{8'hFF, 8'hAB, 8'hCD, 3, 8'hFF, 8'hAB, 8'hCD};
        tbl[7] = '{8'h02, 8'h10, 8'h20, 1, 8'h02, 8'h00, 8'h00};
        tbl[8] = '{8'h06, 8'hEE, 8'h0D, 3, 8'h06, 8'hEE, 8'h0D};
        m4 = '{8'h05, 8'hFF, 8'h00, 8'h06, 8'h00, 8'h00, 8'h04, 8'hAA,
               8'h05, 8'h00, 8'h01, 8'h06, 8'h00, 8'h00, 8'h04, 8'hBB,
               8'h05, 8'h01, 8'h01, 8'h06, 8'h00, 8'h00, 8'h04, 8'hCC,
               8'h05, 8'h02, 8'h01, 8'h06, 8'h00, 8'h00, 8'h04, 8'hDD};

        rst = 1'b1;
        clk_en = 1'b1;
        b1.i_cmd_valid = 1'b0; b1.i_cmd_kind = 1'b0;
        b1.i_opcode = 8'h00; b1.i_arg_a = 8'h00; b1.i_arg_b = 8'h00;
        b1.i_addr = 32'd0; b1.i_wdata = 32'd0; b1.i_out_ready = 1'b1;
        b0.i_cmd_valid = 1'b0; b0.i_cmd_kind = 1'b0;
        b0.i_opcode = 8'h00; b0.i_arg_a = 8'h00; b0.i_arg_b = 8'h00;
        b0.i_addr = 32'd0; b0.i_wdata = 32'd0; b0.i_out_ready = 1'b1;

        repeat (3) tick();
        chk("rst_state",
            {b1.o_valid, b1.o_data, b1.o_cmd_ready, b1.o_busy},
            {1'b0, 8'h00, 1'b0, 1'b1});
        chk("rst_nosync", {b0.o_valid, b0.o_cmd_ready, b0.o_busy}, 3'b010);
        rst = 1'b0;
        tick();
        chk("nosync_ready", {b0.o_valid, b0.o_cmd_ready, b0.o_busy}, 3'b010);
        wait_idle(cyc);
        exq.push_back(8'hA5);
        compare_q("sync");

        // NOP then WRITE back-to-back with a single idle cycle between
        send(1'b0, 8'h00, 8'h99, 8'h88, 32'd0, 32'd0, 1'b1, 8'h00);
        tick();
        chk("gap", {b1.o_valid, b1.o_cmd_ready}, 2'b01);
        send(1'b0, 8'h04, 8'h5A, 8'h00, 32'd0, 32'd0, 1'b1, 8'h04);
        wait_idle(cyc);
        exq = '{8'h00, 8'h04, 8'h5A};
        compare_q("nop_write");

        for (int i = 0; i < 9; i++) begin
            exq.push_back(tbl[i].e0);
            if (tbl[i].n > 1) exq.push_back(tbl[i].e1);
            if (tbl[i].n > 2) exq.push_back(tbl[i].e2);
            send(1'b0, tbl[i].opc, tbl[i].a, tbl[i].b, 32'd0, 32'd0,
                 1'b1, tbl[i].e0);
            wait_idle(cyc);
            chk("tbl_cycles", cyc, tbl[i].n);
            compare_q("tbl");
        end

        send(1'b0, 8'h06, 8'h78, 8'h56, 32'd0, 32'd0, 1'b1, 8'h06);
        foreach (tbl[i]) if (i < 6) begin
            b1.i_out_ready = (i == 1 || i == 4 || i == 5);
            tick();
        end
        b1.i_out_ready = 1'b1;
        wait_idle(cyc);
        exq = '{8'h06, 8'h78, 8'h56};
        compare_q("backpressure");

        send(1'b0, 8'h06, 8'h9A, 8'hBC, 32'd0, 32'd0, 1'b1, 8'h06);
        tick();
        clk_en = 1'b0;
        repeat (3) tick();
        chk("freeze", {b1.o_valid, b1.o_data}, {1'b1, 8'h9A});
        clk_en = 1'b1;
        wait_idle(cyc);
        exq = '{8'h06, 8'h9A, 8'hBC};
        compare_q("clk_en");

        foreach (m4[i]) exq.push_back(m4[i]);
        send(1'b1, 8'h00, 8'h00, 8'h00, 32'h0000_00FF, 32'hDDCC_BBAA,
             1'b1, 8'h05);
        wait_idle(cyc);
        chk("macro_cycles", cyc, 32);
        compare_q("macro");

        push_model(1'b1, 8'h00, 8'h00, 8'h00, 32'hFFFF_FFFE, 32'h4433_2211);
        chk("wrap_model", {exq[9], exq[10], exq[17], exq[20]},
            {8'hFF, 8'hFF, 8'h00, 8'h00});
        send(1'b1, 8'h00, 8'h00, 8'h00, 32'hFFFF_FFFE, 32'h4433_2211,
             1'b1, 8'h05);
        wait_idle(cyc);
        compare_q("macro_wrap");

        push_model(1'b1, 8'h00, 8'h00, 8'h00, 32'h1234_5678, 32'hCAFE_F00D);
        send(1'b1, 8'h00, 8'h00, 8'h00, 32'h1234_5678, 32'hCAFE_F00D,
             1'b1, 8'h05);
        n = 0;
        while (rx.size() < 10 && n < 100) begin
            tick();
            n++;
        end
        chk("pre_rst_count", rx.size(), 10);
        rst = 1'b1;
        tick();
        chk("mid_rst",
            {b1.o_valid, b1.o_cmd_ready, b1.o_busy}, 3'b001);
        while (exq.size() > 10) void'(exq.pop_back());
        compare_q("pre_rst");
        rst = 1'b0;
        wait_idle(cyc);
        exq.push_back(8'hA5);
        compare_q("resync");
        send(1'b0, 8'h01, 8'h33, 8'h44, 32'd0, 32'd0, 1'b1, 8'h01);
        wait_idle(cyc);
        chk("boot_cycles", cyc, 1);
        exq.push_back(8'h01);
        compare_q("boot");

        rnd = 1;
        garbage = 1;
        for (int i = 0; i < 40; i++) begin
            k  = ($urandom_range(0, 3) == 0);
            op = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                             : 8'($urandom_range(0, 9));
            ad = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            wd = $urandom;
            n  = $urandom;
            push_model(k, op, 8'(n), 8'(n >> 8), ad, wd);
            send(k, op, 8'(n), 8'(n >> 8), ad, wd, 1'b0, 8'h00);
            if ($urandom_range(0, 1) == 1) wait_idle(cyc);
        end
        wait_idle(cyc);
        rnd = 0;
        garbage = 0;
        clk_en = 1'b1;
        b1.i_out_ready = 1'b1;
        compare_q("random");
        chk("nosync_bytes", b0_bytes, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
